// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used for the per-bit add step.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a+b+cin one bit per clock, LSB first, and
// reports sum, unsigned carry-out and signed overflow with a done pulse.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, ovf_r;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == ADD) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            sum_r  <= '0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == ADD) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            // sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
            sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
            carry <= fa_cout;
            if (last_bit) begin
                cnt    <= '0;
                cout_r <= fa_cout;
                ovf_r  <= carry ^ fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign ready    = (state == IDLE);
    assign done     = (state == DONE);
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high, one clock, no other clock domain.
REQ-004 start  input  1  request to add; accepted only on a rising edge where ready=1.
REQ-005 a  input  WIDTH  augend, sampled at the accepting edge.
REQ-006 b  input  WIDTH  addend, sampled at the accepting edge.
REQ-007 cin  input  1  carry-in, sampled at the accepting edge.
REQ-008 ready  output  1  high only in IDLE; the block can accept start.
REQ-009 sum  output  WIDTH  result of a+b+cin, modulo 2^WIDTH.
REQ-010 cout  output  1  carry out of the MSB (unsigned overflow).
REQ-011 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-012 done  output  1  one-cycle pulse marking sum/cout/overflow valid.

Function
REQ-013 FSM states IDLE, ADD, DONE; no other reachable states.
REQ-014 IDLE: start=1 at edge E0 latches a, b, cin into shift registers, clears the bit counter and sum register, and moves to ADD.
REQ-015 IDLE with start=0 remains in IDLE; operand inputs are ignored.
REQ-016 ADD: each edge adds one bit pair, LSB first, through the full-adder sub-module; the sum bit shifts into the sum register from the MSB side; the carry register takes the adder carry.
REQ-017 The bit counter increments once per ADD edge; the counter width is ceil(log2(WIDTH)).
REQ-018 The edge that processes bit WIDTH-1 (edge E_WIDTH) moves the FSM to DONE; the counter wraps to 0 at that edge.
REQ-019 At edge E_WIDTH, overflow is captured as carry-in-to-MSB XOR carry-out-of-MSB; cout is captured as the final carry.
REQ-020 DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE unconditionally.
REQ-021 Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the accepting edge; ready rises one cycle after done.
REQ-022 start asserted in ADD or DONE is ignored with no side effects; it is neither queued nor remembered.
REQ-023 sum, cout and overflow hold their values from the done cycle until the next accepted start, which clears them.
REQ-024 A start held continuously issues a new operation on every IDLE cycle; throughput is one result per WIDTH+2 cycles.
REQ-025 Changes on a, b or cin after the accepting edge do not affect the result in progress.

Reset
REQ-026 rst=1 at any edge, including mid-ADD or during DONE, forces IDLE, aborts the operation and clears all shift, carry and counter registers.
REQ-027 Reset output values: ready=1 and sum=0, cout=0, overflow=0, done=0, all visible in the cycle after the reset edge.
REQ-028 rst takes priority over start at the same edge; a start coinciding with rst is dropped.

Structure
REQ-029 The shared package serial_arith_pkg holds the FSM state encodings (IDLE=2'b00, ADD=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-030 One sub-module, full_adder (inputs a, b, cin; outputs sum, cout; purely combinational), is instantiated once for the per-bit add.
REQ-031 All sequential logic sits in serial_adder; it contains no latches and no gated or derived clocks.

Verification (WIDTH=8)
REQ-032 Basic add: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, overflow=0; done exactly 9 cycles after the accepting edge.
REQ-033 Unsigned wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
REQ-034 Signed overflow plus carry-in: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
REQ-035 Busy start: pulse start with a=0x55, b=0x55 at cycle 3 of an add of 0x01+0x02 -> result 0x03; only one done pulse; ready stays 0 until one cycle after done.
REQ-036 Reset mid-op: assert rst at cycle 4 of ADD -> next cycle ready=1, sum=0, cout=0, done=0; no done pulse follows.
REQ-037 Back-to-back: start held high for two operations, 0x10+0x20 then 0x80+0x80 -> sums 0x30 then 0x00 with cout=1 and overflow=1; the done pulses are 10 cycles apart.
